// File: rtl/nor_bist_pkg.sv
// Shared types, constants and the reference NOR function used by the NOR gate BIST controller.
package nor_bist_pkg;

    localparam int NUM_VECTORS = 4;
    localparam int IDX_W       = 2;
    localparam int ERR_CNT_W   = 3;
    localparam int SETTLE_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    function automatic logic nor_expect(input logic a, input logic b);
        return ~(a | b);
    endfunction

endpackage

// File: rtl/nor_bist_if.sv
// Host and gate-side signals of the NOR BIST controller; the fail log appears with NOR_BIST_FAILLOG_EN.
interface nor_bist_if;
    import nor_bist_pkg::*;

    logic                 start;
    logic                 gate_a;
    logic                 gate_b;
    logic                 gate_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_CNT_W-1:0] err_cnt;
`ifdef NOR_BIST_FAILLOG_EN
    logic [IDX_W-1:0]     first_fail;
    logic                 fail_valid;
`endif

    // The controller side: takes start and the gate response, drives everything else.
    modport slave (
        input  start,
        input  gate_out,
        output gate_a,
        output gate_b,
        output busy,
        output done,
        output pass,
        output err_cnt
`ifdef NOR_BIST_FAILLOG_EN
        ,
        output first_fail,
        output fail_valid
`endif
    );

    modport master (
        output start,
        output gate_out,
        input  gate_a,
        input  gate_b,
        input  busy,
        input  done,
        input  pass,
        input  err_cnt
`ifdef NOR_BIST_FAILLOG_EN
        ,
        input  first_fail,
        input  fail_valid
`endif
    );

endinterface

// File: rtl/bist_settle_timer.sv
// Down-counter that times the settle window; expired is high in the last settle cycle.
module bist_settle_timer
    import nor_bist_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [SETTLE_W-1:0] count_i,
    output logic                expired_o
);

    logic [SETTLE_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = count_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q <= SETTLE_W'(1));

endmodule

// File: rtl/nor_bist_ctrl.sv
// NOR gate truth-table BIST controller: sweeps {a,b} = 00..11, samples after a settle window, counts mismatches.
// Optional first-failure log enabled by defining NOR_BIST_FAILLOG_EN.
module nor_bist_ctrl
    import nor_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    nor_bist_if.slave  bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);
    localparam bit                  HAS_SETTLE = (SETTLE_CYCLES != 0);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_VECTORS - 1);

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic                 pass_q, pass_d;
    logic                 done_q, done_d;
    logic                 settle_load;
    logic                 settle_expired;
    logic                 in_sweep;
    logic                 mismatch;

    bist_settle_timer u_settle (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (settle_load),
        .count_i   (SETTLE_VAL),
        .expired_o (settle_expired)
    );

    assign in_sweep = (state_q == DRIVE) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign {bus.gate_a, bus.gate_b} = in_sweep ? idx_q : '0;

    // Case equality makes an X/Z response from the gate count as a mismatch.
    assign mismatch = (bus.gate_out === nor_expect(bus.gate_a, bus.gate_b)) ? 1'b0 : 1'b1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        pass_d      = pass_q;
        done_d      = 1'b0;
        settle_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    err_d   = '0;
                    pass_d  = 1'b0;
                    idx_d   = '0;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                settle_load = 1'b1;
                state_d     = HAS_SETTLE ? SETTLE : SAMPLE;
            end
            SETTLE: begin
                if (settle_expired) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                pass_d  = (err_q == '0);
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy    = in_sweep;
    assign bus.done    = done_q;
    assign bus.pass    = pass_q;
    assign bus.err_cnt = err_q;

`ifdef NOR_BIST_FAILLOG_EN
    logic [IDX_W-1:0] first_q, first_d;
    logic             fvalid_q, fvalid_d;

    always_comb begin
        first_d  = first_q;
        fvalid_d = fvalid_q;
        if (state_q == IDLE && bus.start) begin
            first_d  = '0;
            fvalid_d = 1'b0;
        end else if (state_q == SAMPLE && mismatch && !fvalid_q) begin
            first_d  = idx_q;
            fvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= '0;
            fvalid_q <= 1'b0;
        end else begin
            first_q  <= first_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign bus.first_fail = first_q;
    assign bus.fail_valid = fvalid_q;
`endif

endmodule

// File: doc/nor_bist_ctrl.md
NOR_BIST_CTRL -- requirements
Module: nor_bist_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 2 (range 0..15): idle cycles between driving a vector and sampling the gate output.
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1: one-cycle request to run a full truth-table sweep.
REQ-005 The block SHALL have port gate_a, output, 1: drives the device-under-test input a.
REQ-006 The block SHALL have port gate_b, output, 1: drives the device-under-test input b.
REQ-007 The block SHALL have port gate_out, input, 1: device-under-test output, expected to be NOR(a,b).
REQ-008 The block SHALL have port busy, output, 1: high while a sweep is in progress.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when a sweep completes.
REQ-010 The block SHALL have port pass, output, 1: high when the last completed sweep had zero mismatches.
REQ-011 The block SHALL have port err_cnt, output, 3: count of mismatching vectors in the current or last sweep (0..4).

Function
REQ-012 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-013 In IDLE, start=1 SHALL clear err_cnt and pass, set vector index to 0 and move to DRIVE on the next edge.
REQ-014 DRIVE SHALL set {gate_a,gate_b} = vector index (MSB = a), and SHALL last 1 cycle.
REQ-015 From DRIVE, the FSM SHALL go to SETTLE when SETTLE_CYCLES>0, otherwise directly to SAMPLE.
REQ-016 SETTLE SHALL last exactly SETTLE_CYCLES cycles, with gate_a and gate_b held stable.
REQ-017 SAMPLE SHALL compare gate_out with ~(gate_a|gate_b) and increment err_cnt on mismatch.
REQ-018 A gate_out value that is neither 0 nor 1 (X/Z) SHALL count as a mismatch.
REQ-019 After SAMPLE, the FSM SHALL go to DRIVE with index+1 if the index is below 3, otherwise to DONE.
REQ-020 The vector order SHALL be 00, 01, 10, 11 for {a,b}.
REQ-021 DONE SHALL assert done for 1 cycle, set pass = (err_cnt==0), and return to IDLE.
REQ-022 The done pulse SHALL occur 4*(2+SETTLE_CYCLES)+1 cycles after the edge that samples start (17 cycles for the default).
REQ-023 busy SHALL be high in DRIVE, SETTLE and SAMPLE, and low in IDLE and DONE.
REQ-024 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-025 pass and err_cnt SHALL hold their values from DONE until the next accepted start.
REQ-026 In IDLE, gate_a and gate_b SHALL be 0.

Reset
REQ-027 While rst_n=0, the block SHALL immediately set the state to IDLE, the vector index to 0, and all outputs to 0.
REQ-028 Reset mid-sweep SHALL abort the sweep with no done pulse; pass remains 0 until a full sweep completes.

Configuration
REQ-029 With NOR_BIST_FAILLOG_EN defined, the block SHALL add output first_fail, 2 bits: the vector index of the first mismatch in the sweep, plus output fail_valid, 1 bit, set at that mismatch.
REQ-030 first_fail and fail_valid SHALL be cleared by an accepted start and by reset.
REQ-031 Without NOR_BIST_FAILLOG_EN, those ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-032 A shared package nor_bist_pkg SHALL hold the FSM state typedef, the vector count constant (4), and the expected-output function.
REQ-033 The settle counter SHALL be a sub-module bist_settle_timer with inputs load and count value, and output expired.

Verification
REQ-034 Correct NOR model, SETTLE_CYCLES=2, pulse start -> done at cycle 17; pass=1, err_cnt=0.
REQ-035 gate_out stuck at 0 -> err_cnt=1, pass=0; with the macro, first_fail=00 and fail_valid=1.
REQ-036 gate_out stuck at 1 -> err_cnt=3, pass=0; with the macro, first_fail=01.
REQ-037 SETTLE_CYCLES=0 -> done at cycle 9, and the SETTLE state is never entered.
REQ-038 start pulsed during SAMPLE of vector 01 -> ignored; exactly one done.
REQ-039 rst_n low during SETTLE of vector 10 -> outputs 0 at once, no done; a new start afterwards completes normally.
